// File: rtl/jump_ctrl_pkg.sv
// Shared constants for jump-instruction decoding and the 55-bit ALU/PC control word.
// Field positions here are the single source of truth for every decoder that builds or slices the word.
package jump_ctrl_pkg;

    localparam int CW_WIDTH = 55;

    localparam int PC_INC_POS    = 54;
    localparam int ALU_OP_LSB    = 50;
    localparam int ALU_OP_W      = 4;
    localparam int A_ALTERN_LSB  = 34;
    localparam int B_ALTERN_LSB  = 18;
    localparam int ALTERN_W      = 16;
    localparam int A_SEL_LSB     = 14;
    localparam int B_SEL_LSB     = 10;
    localparam int SEL_W         = 4;
    localparam int A_SRC_POS     = 9;
    localparam int B_SRC_POS     = 8;
    localparam int OUT_SEL_LSB   = 4;
    localparam int LOAD_SRC_LSB  = 2;
    localparam int LOAD_SRC_W    = 2;
    localparam int STORE_STK_POS = 1;
    localparam int STORE_MEM_POS = 0;

    localparam int FLAG_W = 16;
    localparam int INSTR_W = 12;

    typedef enum logic [3:0] {
        COND_ALWAYS  = 4'h0,
        COND_NEVER   = 4'h1,
        COND_Z       = 4'h2,
        COND_NZ      = 4'h3,
        COND_S       = 4'h4,
        COND_NS      = 4'h5,
        COND_V       = 4'h6,
        COND_NV      = 4'h7,
        COND_E       = 4'h8,
        COND_NE      = 4'h9,
        COND_NZ_NS   = 4'hA,
        COND_Z_OR_S  = 4'hB,
        COND_RSV_C   = 4'hC,
        COND_RSV_D   = 4'hD,
        COND_RSV_E   = 4'hE,
        COND_RSV_F   = 4'hF
    } cond_e;

    localparam logic [ALU_OP_W-1:0] ALU_NOP    = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_PASS_A = 4'h1;

    typedef enum logic [LOAD_SRC_W-1:0] {
        LOAD_NONE  = 2'b00,
        LOAD_ALU   = 2'b01,
        LOAD_MEM   = 2'b10,
        LOAD_STACK = 2'b11
    } load_src_e;

    localparam logic SRC_REG    = 1'b0;
    localparam logic SRC_ALTERN = 1'b1;

    localparam logic [SEL_W-1:0] PC_SEL = 4'hF;

endpackage

// File: rtl/alu_control_word_fields.sv
// Purely combinational slicer from a 55-bit control word to its named datapath fields.
// Shared by every instruction decoder, so it must stay free of logic beyond wiring.
module alu_control_word_fields
    import jump_ctrl_pkg::*;
(
    input  logic [CW_WIDTH-1:0]   control_word,
    output logic                  program_counter_increment,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [ALTERN_W-1:0]   alu_a_altern,
    output logic [ALTERN_W-1:0]   alu_b_altern,
    output logic [SEL_W-1:0]      alu_a_select,
    output logic [SEL_W-1:0]      alu_b_select,
    output logic                  alu_a_source,
    output logic                  alu_b_source,
    output logic [SEL_W-1:0]      alu_out_select,
    output logic [LOAD_SRC_W-1:0] alu_load_src,
    output logic                  alu_store_to_stk,
    output logic                  alu_store_to_mem
);

    assign program_counter_increment = control_word[PC_INC_POS];
    assign alu_op                    = control_word[ALU_OP_LSB +: ALU_OP_W];
    assign alu_a_altern              = control_word[A_ALTERN_LSB +: ALTERN_W];
    assign alu_b_altern              = control_word[B_ALTERN_LSB +: ALTERN_W];
    assign alu_a_select              = control_word[A_SEL_LSB +: SEL_W];
    assign alu_b_select              = control_word[B_SEL_LSB +: SEL_W];
    assign alu_a_source              = control_word[A_SRC_POS];
    assign alu_b_source              = control_word[B_SRC_POS];
    assign alu_out_select            = control_word[OUT_SEL_LSB +: SEL_W];
    assign alu_load_src              = control_word[LOAD_SRC_LSB +: LOAD_SRC_W];
    assign alu_store_to_stk          = control_word[STORE_STK_POS];
    assign alu_store_to_mem          = control_word[STORE_MEM_POS];

endmodule

// File: rtl/jump_control_path.sv
// Registered jump decoder: tests the selected per-register flags against the condition code
// and captures the resulting ALU/PC control word once per clock.
module jump_control_path
    import jump_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic [FLAG_W-1:0]     zeroflag,
    input  logic [FLAG_W-1:0]     signflag,
    input  logic [FLAG_W-1:0]     overflow,
    input  logic [FLAG_W-1:0]     errorbit,
    output logic [CW_WIDTH-1:0]   control_word,
    output logic                  program_counter_increment,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [ALTERN_W-1:0]   alu_a_altern,
    output logic [ALTERN_W-1:0]   alu_b_altern,
    output logic [SEL_W-1:0]      alu_a_select,
    output logic [SEL_W-1:0]      alu_b_select,
    output logic                  alu_a_source,
    output logic                  alu_b_source,
    output logic [SEL_W-1:0]      alu_out_select,
    output logic [LOAD_SRC_W-1:0] alu_load_src,
    output logic                  alu_store_to_stk,
    output logic                  alu_store_to_mem
);

    cond_e               cond;
    logic [3:0]          flag_idx;
    logic [SEL_W-1:0]    target_reg;
    logic                z_flag;
    logic                s_flag;
    logic                v_flag;
    logic                e_flag;
    logic                taken;
    logic [CW_WIDTH-1:0] next_word;

    assign cond       = cond_e'(instruction[11:8]);
    assign flag_idx   = instruction[7:4];
    assign target_reg = instruction[3:0];

    assign z_flag = zeroflag[flag_idx];
    assign s_flag = signflag[flag_idx];
    assign v_flag = overflow[flag_idx];
    assign e_flag = errorbit[flag_idx];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
            COND_Z:      taken = z_flag;
            COND_NZ:     taken = ~z_flag;
            COND_S:      taken = s_flag;
            COND_NS:     taken = ~s_flag;
            COND_V:      taken = v_flag;
            COND_NV:     taken = ~v_flag;
            COND_E:      taken = e_flag;
            COND_NE:     taken = ~e_flag;
            COND_NZ_NS:  taken = ~z_flag & ~s_flag;
            COND_Z_OR_S: taken = z_flag | s_flag;
            default:     taken = 1'b0;
        endcase
    end

    // A taken jump routes register r through the ALU into the PC; not-taken just steps the PC.
    always_comb begin
        next_word = '0;
        if (instr_valid) begin
            if (taken) begin
                next_word[ALU_OP_LSB +: ALU_OP_W]       = ALU_PASS_A;
                next_word[A_SEL_LSB +: SEL_W]           = target_reg;
                next_word[A_SRC_POS]                    = SRC_REG;
                next_word[B_SRC_POS]                    = SRC_ALTERN;
                next_word[OUT_SEL_LSB +: SEL_W]         = PC_SEL;
                next_word[LOAD_SRC_LSB +: LOAD_SRC_W]   = LOAD_ALU;
            end else begin
                next_word[PC_INC_POS] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control_word <= '0;
        end else begin
            control_word <= next_word;
        end
    end

    alu_control_word_fields u_fields (
        .control_word              (control_word),
        .program_counter_increment (program_counter_increment),
        .alu_op                    (alu_op),
        .alu_a_altern              (alu_a_altern),
        .alu_b_altern              (alu_b_altern),
        .alu_a_select              (alu_a_select),
        .alu_b_select              (alu_b_select),
        .alu_a_source              (alu_a_source),
        .alu_b_source              (alu_b_source),
        .alu_out_select            (alu_out_select),
        .alu_load_src              (alu_load_src),
        .alu_store_to_stk          (alu_store_to_stk),
        .alu_store_to_mem          (alu_store_to_mem)
    );

endmodule

// File: tb/tb_jump_control_path.sv
// Self-checking bench for jump_control_path: directed and random jumps compared against
// a condition-table reference model, with outputs sampled 1ns after each rising edge.
module tb_jump_control_path;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [11:0] instruction;
    logic [15:0] zeroflag;
    logic [15:0] signflag;
    logic [15:0] overflow;
    logic [15:0] errorbit;
    logic [54:0] control_word;
    logic        program_counter_increment;
    logic [3:0]  alu_op;
    logic [15:0] alu_a_altern;
    logic [15:0] alu_b_altern;
    logic [3:0]  alu_a_select;
    logic [3:0]  alu_b_select;
    logic        alu_a_source;
    logic        alu_b_source;
    logic [3:0]  alu_out_select;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_stk;
    logic        alu_store_to_mem;

    int assertCount = 0;
    int failCount   = 0;

    jump_control_path dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .instr_valid               (instr_valid),
        .instruction               (instruction),
        .zeroflag                  (zeroflag),
        .signflag                  (signflag),
        .overflow                  (overflow),
        .errorbit                  (errorbit),
        .control_word              (control_word),
        .program_counter_increment (program_counter_increment),
        .alu_op                    (alu_op),
        .alu_a_altern              (alu_a_altern),
        .alu_b_altern              (alu_b_altern),
        .alu_a_select              (alu_a_select),
        .alu_b_select              (alu_b_select),
        .alu_a_source              (alu_a_source),
        .alu_b_source              (alu_b_source),
        .alu_out_select            (alu_out_select),
        .alu_load_src              (alu_load_src),
        .alu_store_to_stk          (alu_store_to_stk),
        .alu_store_to_mem          (alu_store_to_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table, written straight from the jump condition list.
    function automatic bit refTaken(input int cond, input bit z, input bit s, input bit v, input bit e);
        case (cond)
            0:  return 1'b1;
            1:  return 1'b0;
            2:  return z;
            3:  return !z;
            4:  return s;
            5:  return !s;
            6:  return v;
            7:  return !v;
            8:  return e;
            9:  return !e;
            10: return !z && !s;
            11: return z || s;
            default: return 1'b0;
        endcase
    endfunction

    // Expected word built by arithmetic from the documented field positions.
    function automatic logic [54:0] refWord(input bit valid, input bit taken, input logic [3:0] r);
        logic [54:0] w;
        w = 55'd0;
        if (valid && taken)
            w = (55'd1 << 50) | (55'(r) << 14) | (55'd1 << 8) | (55'd15 << 4) | (55'd1 << 2);
        else if (valid)
            w = 55'd1 << 54;
        return w;
    endfunction

    task automatic checkField(input string tag, input logic [54:0] obs, input logic [54:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input bit valid, input bit taken, input logic [3:0] r);
        bit tk;
        tk = valid && taken;
        checkField({tag, " word"},      control_word, refWord(valid, taken, r));
        checkField({tag, " pc_inc"},    55'(program_counter_increment), 55'(valid && !taken));
        checkField({tag, " alu_op"},    55'(alu_op), tk ? 55'd1 : 55'd0);
        checkField({tag, " a_altern"},  55'(alu_a_altern), 55'd0);
        checkField({tag, " b_altern"},  55'(alu_b_altern), 55'd0);
        checkField({tag, " a_select"},  55'(alu_a_select), tk ? 55'(r) : 55'd0);
        checkField({tag, " b_select"},  55'(alu_b_select), 55'd0);
        checkField({tag, " a_source"},  55'(alu_a_source), 55'd0);
        checkField({tag, " b_source"},  55'(alu_b_source), 55'(tk));
        checkField({tag, " out_sel"},   55'(alu_out_select), tk ? 55'd15 : 55'd0);
        checkField({tag, " load_src"},  55'(alu_load_src), tk ? 55'd1 : 55'd0);
        checkField({tag, " store_stk"}, 55'(alu_store_to_stk), 55'd0);
        checkField({tag, " store_mem"}, 55'(alu_store_to_mem), 55'd0);
    endtask

    // Drive one instruction at the falling edge and sample 1ns after the capturing rising edge.
    task automatic applyStimulus(input bit valid, input logic [11:0] instr,
                                 input logic [15:0] z, input logic [15:0] s,
                                 input logic [15:0] v, input logic [15:0] e);
        @(negedge clk);
        instr_valid = valid;
        instruction = instr;
        zeroflag    = z;
        signflag    = s;
        overflow    = v;
        errorbit    = e;
        @(posedge clk);
        #1;
    endtask

    function automatic bit modelTaken(input logic [11:0] instr, input logic [15:0] z,
                                      input logic [15:0] s, input logic [15:0] v,
                                      input logic [15:0] e);
        int f;
        f = int'(instr[7:4]);
        return refTaken(int'(instr[11:8]), z[f], s[f], v[f], e[f]);
    endfunction

    initial begin
        logic [11:0] instr;
        logic [15:0] rz, rs, rv, re;
        bit          valid;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        zeroflag    = '0;
        signflag    = '0;
        overflow    = '0;
        errorbit    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 12'h235, 16'h0008, 16'h0, 16'h0, 16'h0);
        checkField("directed taken word", control_word, 55'h40000000141F4);
        checkOutput("directed taken", 1'b1, 1'b1, 4'd5);

        applyStimulus(1'b1, 12'h235, 16'h0000, 16'h0, 16'h0, 16'h0);
        checkField("directed not-taken word", control_word, 55'h40000000000000);
        checkOutput("directed not-taken", 1'b1, 1'b0, 4'd5);

        applyStimulus(1'b0, 12'h035, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        checkOutput("idle", 1'b0, 1'b0, 4'd5);

        // Sweep every condition against every Z/S/V/E pattern at flag index 7.
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 16; p++) begin
                instr = {4'(c), 4'd7, 4'($urandom_range(15))};
                rz = p[0] ? 16'h0080 : 16'hFF7F;
                rs = p[1] ? 16'h0080 : 16'hFF7F;
                rv = p[2] ? 16'h0080 : 16'hFF7F;
                re = p[3] ? 16'h0080 : 16'hFF7F;
                applyStimulus(1'b1, instr, rz, rs, rv, re);
                checkOutput($sformatf("sweep c%0h p%0h", c, p), 1'b1,
                            refTaken(c, p[0], p[1], p[2], p[3]), instr[3:0]);
            end
        end

        // Back-to-back alternating always/never jumps.
        for (int i = 0; i < 8; i++) begin
            instr = {(i % 2 == 0) ? 4'h0 : 4'h1, 4'($urandom_range(15)), 4'($urandom_range(15))};
            applyStimulus(1'b1, instr, 16'h0, 16'h0, 16'h0, 16'h0);
            checkOutput($sformatf("alternate %0d", i), 1'b1, (i % 2 == 0), instr[3:0]);
        end

        // Random instructions, flags and valid.
        for (int i = 0; i < 200; i++) begin
            valid = ($urandom_range(3) != 0);
            instr = 12'($urandom);
            rz = 16'($urandom);
            rs = 16'($urandom);
            rv = 16'($urandom);
            re = 16'($urandom);
            applyStimulus(valid, instr, rz, rs, rv, re);
            checkOutput($sformatf("random %0d", i), valid,
                        modelTaken(instr, rz, rs, rv, re), instr[3:0]);
        end

        // Asynchronous reset mid-stream clears the word at once and discards the pending jump.
        applyStimulus(1'b1, 12'h0A3, 16'h0, 16'h0, 16'h0, 16'h0);
        checkOutput("pre-reset taken", 1'b1, 1'b1, 4'd3);
        @(negedge clk);
        instruction = 12'h0A4;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset immediate", 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("reset held over edge", 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 12'h1A4, 16'h0, 16'h0, 16'h0, 16'h0);
        checkOutput("post-reset not-taken", 1'b1, 1'b0, 4'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
